// File: rtl/vector_lane_sequencer.sv
// Multi-cycle vector unit: one lane per cycle on a shared lane ALU, stalling the execute register while busy.
// Optional lane multiplier for op 1010 is enabled by defining VECTOR_LANE_SEQUENCER_MUL_EN.
module vector_lane_sequencer #(
  parameter int LANES      = 4,
  parameter int LANE_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          sync_reset,
  input  logic                          start,
  input  logic                          flush,
  input  logic [3:0]                    ALU_op_E,
  input  logic                          select_operand_0_vector_E,
  input  logic                          select_operand_1_vector_E,
  input  logic                          ALU_source_E,
  input  logic [LANES*LANE_WIDTH-1:0]   vector_reg_data_0_E,
  input  logic [LANES*LANE_WIDTH-1:0]   vector_reg_data_1_E,
  input  logic [LANE_WIDTH-1:0]         scalar_reg_data_0_E,
  input  logic [LANE_WIDTH-1:0]         scalar_reg_data_1_E,
  input  logic [LANE_WIDTH-1:0]         immediate_E,
  input  logic [5:0]                    rd_E,
  output logic                          stall_request,
  output logic                          result_valid,
  output logic [LANES*LANE_WIDTH-1:0]   vector_result,
  output logic [5:0]                    rd_result
);

  localparam int VW    = LANES * LANE_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SH_W  = $clog2(LANE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [VW-1:0]         op_a, op_b, work, work_next;
  logic [VW-1:0]         cap_a, cap_b;
  logic [LANE_WIDTH-1:0] b_scalar, lane_a, lane_b, lane_res;
  logic [SH_W-1:0]       shamt;
  logic [3:0]            op_q;
  logic [5:0]            rd_q;
  logic [CNT_W-1:0]      cnt;
  logic                  capture;
  logic                  run_step;

  // Operand selection happens at capture so the upstream register may move on afterwards.
  always_comb begin
    b_scalar = ALU_source_E ? immediate_E : scalar_reg_data_1_E;
    cap_a    = select_operand_0_vector_E ? vector_reg_data_0_E : {LANES{scalar_reg_data_0_E}};
    cap_b    = select_operand_1_vector_E ? vector_reg_data_1_E : {LANES{b_scalar}};
  end

  always_comb begin
    capture       = (state == IDLE) && start && !flush;
    run_step      = (state == RUN) && !flush;
    stall_request = capture || (state == RUN);
    result_valid  = (state == DONE) && !flush;
  end

  always_comb begin
    lane_a = op_a[cnt*LANE_WIDTH +: LANE_WIDTH];
    lane_b = op_b[cnt*LANE_WIDTH +: LANE_WIDTH];
    shamt  = lane_b[SH_W-1:0];
  end

  always_comb begin
    lane_res = '0;
    case (op_q)
      4'b0000: lane_res = lane_a + lane_b;
      4'b0001: lane_res = lane_a - lane_b;
      4'b0010: lane_res = lane_a & lane_b;
      4'b0011: lane_res = lane_a | lane_b;
      4'b0100: lane_res = lane_a ^ lane_b;
      4'b0101: lane_res = lane_a << shamt;
      4'b0110: lane_res = lane_a >> shamt;
      4'b0111: lane_res = $signed(lane_a) >>> shamt;
      4'b1000: lane_res = {{(LANE_WIDTH-1){1'b0}}, ($signed(lane_a) < $signed(lane_b))};
      4'b1001: lane_res = {{(LANE_WIDTH-1){1'b0}}, (lane_a < lane_b)};
`ifdef VECTOR_LANE_SEQUENCER_MUL_EN
      4'b1010: lane_res = lane_a * lane_b;
`else
      4'b1010: lane_res = '0;
`endif
      default: lane_res = '0;
    endcase
  end

  always_comb begin
    work_next = work;
    work_next[cnt*LANE_WIDTH +: LANE_WIDTH] = lane_res;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = RUN;
      RUN: begin
        if (flush)                  state_next = IDLE;
        else if (cnt == LAST_LANE)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state         <= IDLE;
      op_a          <= '0;
      op_b          <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      cnt           <= '0;
      work          <= '0;
      vector_result <= '0;
      rd_result     <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        op_a <= cap_a;
        op_b <= cap_b;
        op_q <= ALU_op_E;
        rd_q <= rd_E;
        cnt  <= '0;
        work <= '0;
      end
      // Last lane is merged combinationally so the result lands on the RUN->DONE edge.
      if (run_step) begin
        work <= work_next;
        cnt  <= cnt + CNT_W'(1);
        if (cnt == LAST_LANE) begin
          vector_result <= work_next;
          rd_result     <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Scoreboard bench for vector_lane_sequencer: driver pushes expected results, negedge monitor pops on result_valid.
module tb_vector_lane_sequencer;

  logic         clock = 1'b0;
  logic         sync_reset, start, flush;
  logic [3:0]   ALU_op_E;
  logic         select_operand_0_vector_E, select_operand_1_vector_E, ALU_source_E;
  logic [127:0] vector_reg_data_0_E, vector_reg_data_1_E;
  logic [31:0]  scalar_reg_data_0_E, scalar_reg_data_1_E, immediate_E;
  logic [5:0]   rd_E;
  logic         stall_request, result_valid;
  logic [127:0] vector_result;
  logic [5:0]   rd_result;

  int checks = 0;
  int errors = 0;
  logic [133:0] exp_q[$];
  logic [127:0] last_vec;
  logic [5:0]   last_rd;

  always #5 clock = ~clock;

  vector_lane_sequencer #(.LANES(4), .LANE_WIDTH(32)) dut (
    .clock(clock), .sync_reset(sync_reset), .start(start), .flush(flush),
    .ALU_op_E(ALU_op_E),
    .select_operand_0_vector_E(select_operand_0_vector_E),
    .select_operand_1_vector_E(select_operand_1_vector_E),
    .ALU_source_E(ALU_source_E),
    .vector_reg_data_0_E(vector_reg_data_0_E), .vector_reg_data_1_E(vector_reg_data_1_E),
    .scalar_reg_data_0_E(scalar_reg_data_0_E), .scalar_reg_data_1_E(scalar_reg_data_1_E),
    .immediate_E(immediate_E), .rd_E(rd_E),
    .stall_request(stall_request), .result_valid(result_valid),
    .vector_result(vector_result), .rd_result(rd_result)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got vector %h rd %0d with nothing expected", vector_result, rd_result);
      end else begin
        logic [133:0] e;
        e = exp_q.pop_front();
        chk("vector_result", vector_result, e[127:0]);
        chk("rd_result", {122'd0, rd_result}, {122'd0, e[133:128]});
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic s0, input logic s1, input logic src,
                        input logic [127:0] va, input logic [127:0] vb,
                        input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] imm,
                        input logic [5:0] rd);
    ALU_op_E = op;
    select_operand_0_vector_E = s0;
    select_operand_1_vector_E = s1;
    ALU_source_E = src;
    vector_reg_data_0_E = va;
    vector_reg_data_1_E = vb;
    scalar_reg_data_0_E = sa;
    scalar_reg_data_1_E = sb;
    immediate_E = imm;
    rd_E = rd;
  endtask

  // Issues one op and checks valid latency (6th negedge sample) and stall length (5 samples).
  task automatic run_op(input string name, input logic [3:0] op, input logic s0, input logic s1,
                        input logic src, input logic [127:0] va, input logic [127:0] vb,
                        input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] imm,
                        input logic [5:0] rd, input logic [127:0] exp, input bit hold);
    int cyc = 0;
    int stall_cnt = 0;
    bit got = 0;
    set_op(op, s0, s1, src, va, vb, sa, sb, imm, rd);
    exp_q.push_back({rd, exp});
    last_vec = exp;
    last_rd  = rd;
    start = 1'b1;
    while (!got && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (stall_request) stall_cnt++;
      if (result_valid) got = 1;
      @(posedge clock);
      #1;
      if (!hold || got) start = 1'b0;
    end
    start = 1'b0;
    chk({name, "_latency"}, 128'(got ? cyc : 0), 128'd6);
    chk({name, "_stall_cycles"}, 128'(stall_cnt), 128'd5);
  endtask

  initial begin
    sync_reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    set_op(4'd0, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0, '0, 6'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_vector", vector_result, 128'd0);
    chk("reset_rd", {122'd0, rd_result}, 128'd0);
    chk("reset_valid_stall", {126'd0, result_valid, stall_request}, 128'd0);
    sync_reset = 1'b0;
    @(posedge clock);
    #1;

    run_op("add", 4'b0000, 1'b1, 1'b1, 1'b0,
           {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd30, 32'd20, 32'd10},
           32'd0, 32'd0, 32'd0, 6'd5, {32'd0, 32'd33, 32'd22, 32'd11}, 0);
    run_op("bcast_sub", 4'b0001, 1'b0, 1'b0, 1'b1,
           {4{32'h55555555}}, {4{32'h12345678}},
           32'd7, 32'd100, 32'hFFFFFFFF, 6'd6, {4{32'd8}}, 0);
    run_op("sra", 4'b0111, 1'b0, 1'b0, 1'b0, '0, '0,
           32'h80000000, 32'd4, 32'd0, 6'd7, {4{32'hF8000000}}, 0);
    run_op("srl", 4'b0110, 1'b0, 1'b0, 1'b0, '0, '0,
           32'h80000000, 32'd4, 32'd0, 6'd8, {4{32'h08000000}}, 0);
    run_op("slt", 4'b1000, 1'b0, 1'b0, 1'b0, '0, '0,
           32'hFFFFFFFF, 32'd0, 32'd0, 6'd9, {4{32'd1}}, 0);
    run_op("sltu", 4'b1001, 1'b0, 1'b0, 1'b0, '0, '0,
           32'hFFFFFFFF, 32'd0, 32'd0, 6'd10, {4{32'd0}}, 0);
    run_op("xor", 4'b0100, 1'b1, 1'b1, 1'b0,
           {32'h0000FFFF, 32'hFFFF0000, 32'h12345678, 32'h00000000},
           {32'hFFFFFFFF, 32'hFFFF0000, 32'h12345678, 32'hAAAA5555},
           32'd0, 32'd0, 32'd0, 6'd11,
           {32'hFFFF0000, 32'h00000000, 32'h00000000, 32'hAAAA5555}, 0);
    run_op("sll", 4'b0101, 1'b1, 1'b0, 1'b0,
           {32'h00000001, 32'h80000001, 32'h0000F00F, 32'h12345678}, '0,
           32'd0, 32'd36, 32'd0, 6'd12,
           {32'h00000010, 32'h00000010, 32'h000F00F0, 32'h23456780}, 0);
    run_op("bad_op", 4'b1111, 1'b1, 1'b1, 1'b0, {4{32'h13572468}}, {4{32'h24681357}},
           32'd0, 32'd0, 32'd0, 6'd13, 128'd0, 0);

    // Flush in the second RUN cycle: no pulse, outputs keep the previous op's values.
    set_op(4'b0000, 1'b1, 1'b1, 1'b0, {4{32'd9}}, {4{32'd9}}, 32'd0, 32'd0, 32'd0, 6'd40);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_stall", {127'd0, stall_request}, 128'd0);
    chk("flush_keep_vector", vector_result, last_vec);
    chk("flush_keep_rd", {122'd0, rd_result}, {122'd0, last_rd});
    repeat (8) @(posedge clock);
    #1;

    run_op("hold_start", 4'b0011, 1'b1, 1'b1, 1'b0,
           {32'hF0000000, 32'h0F000000, 32'h00F00000, 32'h000F0000}, {4{32'h00000001}},
           32'd0, 32'd0, 32'd0, 6'd20,
           {32'hF0000001, 32'h0F000001, 32'h00F00001, 32'h000F0001}, 1);
    repeat (6) @(posedge clock);
    #1;
    chk("hold_single_completion", 128'(exp_q.size()), 128'd0);
    run_op("and_after_hold", 4'b0010, 1'b0, 1'b1, 1'b0, '0,
           {32'hFFFF0000, 32'h0000FFFF, 32'h0F0F0F0F, 32'h00000000},
           32'h12345678, 32'd0, 32'd0, 6'd21,
           {32'h12340000, 32'h00005678, 32'h02040608, 32'h00000000}, 0);

`ifdef VECTOR_LANE_SEQUENCER_MUL_EN
    run_op("mul", 4'b1010, 1'b1, 1'b1, 1'b0, {4{32'd3}}, {4{32'd5}},
           32'd0, 32'd0, 32'd0, 6'd30, {4{32'd15}}, 0);
`else
    run_op("mul", 4'b1010, 1'b1, 1'b1, 1'b0, {4{32'd3}}, {4{32'd5}},
           32'd0, 32'd0, 32'd0, 6'd30, {4{32'd0}}, 0);
`endif

    // Reset asserted during RUN clears everything at the next edge.
    set_op(4'b0000, 1'b1, 1'b1, 1'b0, {4{32'd1}}, {4{32'd1}}, 32'd0, 32'd0, 32'd0, 6'd50);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    sync_reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrun_reset_vector", vector_result, 128'd0);
    chk("midrun_reset_rd", {122'd0, rd_result}, 128'd0);
    chk("midrun_reset_valid_stall", {126'd0, result_valid, stall_request}, 128'd0);
    sync_reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
